// File: rtl/hash_issue_credit_ctrl.sv
// Credit-based issue gate in front of the hash PE array.
// Limits in-flight batches, drains the pipeline on stream delimiters, and
// keeps issue/stall statistics plus a sticky retire-underflow flag.
module hash_issue_credit_ctrl #(
    parameter int PAYLOAD_W = 512,
    parameter int CNT_W     = 6,
    parameter int STAT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_enable,
    input  logic [CNT_W-1:0]     cfg_max_queued_req_num,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_delim,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_delim,
    input  logic                 out_ready,
    input  logic                 retire_valid,
    input  logic                 retire_delim,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 draining,
    output logic [STAT_W-1:0]    stat_issued,
    output logic [STAT_W-1:0]    stat_stall_cycles,
    output logic                 err_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             delim_seen;
    logic             can_issue;
    logic             fire;
    logic             retire_dec;
    logic             retire_underflow;
    logic             drain_entry;

    // Issue gating depends only on registered state/count and cfg, so the
    // out_ready -> in_ready path is purely combinational with no loop.
    always_comb begin
        can_issue        = (state == RUN) && cfg_enable && (count < cfg_max_queued_req_num);
        in_ready         = out_ready && can_issue;
        out_valid        = in_valid && can_issue;
        out_payload      = in_payload;
        out_delim        = in_delim;
        fire             = in_valid && in_ready;
        retire_dec       = retire_valid && (count != '0);
        retire_underflow = retire_valid && (count == '0);
        outstanding      = count;
        draining         = (state == DRAIN);
    end

    // Credit count: simultaneous fire and retire cancel; saturate at the top,
    // never go below zero.
    always_comb begin
        count_next = count;
        if (fire && !retire_dec) begin
            if (count != CNT_MAX) begin
                count_next = count + 1'b1;
            end
        end else if (!fire && retire_dec) begin
            count_next = count - 1'b1;
        end
    end

    // Next-state logic; DRAIN releases one cycle after the pipe is empty and
    // the delimiter batch has been seen retiring.
    always_comb begin
        state_next  = state;
        drain_entry = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fire && in_delim) begin
                    state_next  = DRAIN;
                    drain_entry = 1'b1;
                end else if (!cfg_enable && (count == '0)) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if ((count == '0) && delim_seen) begin
                    state_next = cfg_enable ? RUN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and credit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Delimiter-retired flag, cleared whenever a new drain begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            delim_seen <= 1'b0;
        end else if (drain_entry) begin
            delim_seen <= 1'b0;
        end else if ((state == DRAIN) && retire_valid && retire_delim) begin
            delim_seen <= 1'b1;
        end
    end

    // Statistics (wrap naturally) and the sticky underflow error.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued       <= '0;
            stat_stall_cycles <= '0;
            err_underflow     <= 1'b0;
        end else begin
            if (fire) begin
                stat_issued <= stat_issued + STAT_W'(1);
            end
            if (in_valid && !in_ready && (state != IDLE)) begin
                stat_stall_cycles <= stat_stall_cycles + STAT_W'(1);
            end
            if (retire_underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_issue_credit_ctrl.sv
// Self-checking bench for hash_issue_credit_ctrl: directed scenarios with a
// payload scoreboard fed at presentation time and drained on each issue.
module tb_hash_issue_credit_ctrl;

    localparam int PAYLOAD_W = 512;
    localparam int CNT_W     = 6;
    localparam int STAT_W    = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_enable = 1'b0;
    logic [CNT_W-1:0]     cfg_max_queued_req_num = '0;
    logic                 in_valid = 1'b0;
    logic [PAYLOAD_W-1:0] in_payload = '0;
    logic                 in_delim = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_delim;
    logic                 out_ready = 1'b0;
    logic                 retire_valid = 1'b0;
    logic                 retire_delim = 1'b0;
    logic [CNT_W-1:0]     outstanding;
    logic                 draining;
    logic [STAT_W-1:0]    stat_issued;
    logic [STAT_W-1:0]    stat_stall_cycles;
    logic                 err_underflow;

    int errors = 0;
    int checks = 0;

    logic [PAYLOAD_W:0] exp_q[$];
    int  src_idx   = 0;
    int  src_limit = 0;
    int  delim_at  = -1;
    int  n_fire    = 0;
    bit  last_fire = 1'b0;

    hash_issue_credit_ctrl #(
        .PAYLOAD_W(PAYLOAD_W),
        .CNT_W    (CNT_W),
        .STAT_W   (STAT_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_enable            (cfg_enable),
        .cfg_max_queued_req_num(cfg_max_queued_req_num),
        .in_valid              (in_valid),
        .in_payload            (in_payload),
        .in_delim              (in_delim),
        .in_ready              (in_ready),
        .out_valid             (out_valid),
        .out_payload           (out_payload),
        .out_delim             (out_delim),
        .out_ready             (out_ready),
        .retire_valid          (retire_valid),
        .retire_delim          (retire_delim),
        .outstanding           (outstanding),
        .draining              (draining),
        .stat_issued           (stat_issued),
        .stat_stall_cycles     (stat_stall_cycles),
        .err_underflow         (err_underflow)
    );

    always #5 clk = ~clk;

    // Present a fresh random payload upstream and record it as the next expected issue.
    task automatic present();
        logic [PAYLOAD_W-1:0] p;
        for (int i = 0; i < PAYLOAD_W / 32; i++) p[i*32 +: 32] = $urandom;
        in_payload = p;
        in_delim   = (src_idx == delim_at);
        in_valid   = 1'b1;
        exp_q.push_back({in_delim, p});
        src_idx++;
    endtask

    // Withdraw the source; an un-issued pending payload leaves the scoreboard.
    task automatic stop_src();
        if (in_valid) begin
            in_valid = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        src_limit = src_idx;
    endtask

    // One clock: sample at negedge, score issues, then refill the source after the edge.
    task automatic cyc();
        logic [PAYLOAD_W:0] exp;
        @(negedge clk);
        last_fire = in_valid && in_ready;
        if (last_fire) begin
            n_fire++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_issue: issued with no expected payload");
            end else begin
                exp = exp_q.pop_front();
                if ({out_delim, out_payload} !== exp) begin
                    errors++;
                    $display("FAIL sb_payload: got delim=%0b %h expected delim=%0b %h",
                             out_delim, out_payload[63:0], exp[PAYLOAD_W], exp[63:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (last_fire) in_valid = 1'b0;
        if (!in_valid && (src_idx < src_limit)) present();
    endtask

    task automatic do_reset();
        stop_src();
        retire_valid = 1'b0;
        retire_delim = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        exp_q.delete();
        src_idx   = 0;
        src_limit = 0;
        delim_at  = -1;
    endtask

    task automatic test_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd4;
        out_ready = 1'b1;
        rst = 1'b1;
        cyc();
        in_valid = 1'b1;
        cyc();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (outstanding !== 6'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (draining !== 1'b0) begin errors++; $display("FAIL reset_draining: got %0b expected 0", draining); end
        checks++; if (stat_issued !== 32'd0 || stat_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_issued, stat_stall_cycles); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_underflow); end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_and_steady();
        int first, last, s0, f0;
        do_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd4;
        out_ready = 1'b1;
        src_limit = 1000;
        present();
        n_fire = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (last_fire) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++; if (n_fire != 4) begin errors++; $display("FAIL fill_count: got %0d expected 4", n_fire); end
        checks++; if (first != 1 || last != 4) begin errors++; $display("FAIL fill_cycles: got %0d..%0d expected 1..4", first, last); end
        checks++; if (outstanding !== 6'd4) begin errors++; $display("FAIL fill_outstanding: got %0d expected 4", outstanding); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %0b expected 0", in_ready); end
        checks++; if (stat_issued !== 32'd4) begin errors++; $display("FAIL fill_stat_issued: got %0d expected 4", stat_issued); end
        checks++; if (stat_stall_cycles !== 32'd3) begin errors++; $display("FAIL fill_stall_total: got %0d expected 3", stat_stall_cycles); end
        for (int i = 0; i < 3; i++) begin
            s0 = int'(stat_stall_cycles);
            cyc();
            checks++; if (int'(stat_stall_cycles) != s0 + 1) begin
                errors++; $display("FAIL stall_incr: got %0d expected %0d", stat_stall_cycles, s0 + 1); end
        end
        // Steady state: retire every cycle from here on.
        retire_valid = 1'b1;
        cyc();
        checks++; if (last_fire || outstanding !== 6'd3) begin
            errors++; $display("FAIL steady_first: got fire=%0b out=%0d expected fire=0 out=3", last_fire, outstanding); end
        f0 = n_fire;
        for (int i = 0; i < 6; i++) begin
            cyc();
            checks++; if (!last_fire || outstanding !== 6'd3) begin
                errors++; $display("FAIL steady_cycle: got fire=%0b out=%0d expected fire=1 out=3", last_fire, outstanding); end
        end
        checks++; if (n_fire - f0 != 6) begin errors++; $display("FAIL steady_count: got %0d expected 6", n_fire - f0); end
        retire_valid = 1'b0;
        stop_src();
    endtask

    task automatic test_drain();
        do_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd8;
        out_ready = 1'b1;
        delim_at  = 2;
        src_limit = 1000;
        present();
        n_fire = 0;
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (n_fire != 3) begin errors++; $display("FAIL drain_issue_count: got %0d expected 3", n_fire); end
        checks++; if (draining !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL drain_enter: got draining=%0b in_ready=%0b expected 1/0", draining, in_ready); end
        retire_valid = 1'b1; retire_delim = 1'b0;
        cyc();
        cyc();
        retire_delim = 1'b1;
        cyc();
        retire_valid = 1'b0; retire_delim = 1'b0;
        checks++; if (n_fire != 3) begin errors++; $display("FAIL drain_no_issue: got %0d expected 3", n_fire); end
        checks++; if (outstanding !== 6'd0 || draining !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL drain_dwell: got out=%0d draining=%0b in_ready=%0b expected 0/1/0", outstanding, draining, in_ready); end
        cyc();
        checks++; if (draining !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_exit: got draining=%0b in_ready=%0b expected 0/1", draining, in_ready); end
        cyc();
        checks++; if (!last_fire || stat_issued !== 32'd4) begin
            errors++; $display("FAIL drain_resume: got fire=%0b issued=%0d expected 1/4", last_fire, stat_issued); end
        stop_src();
    endtask

    task automatic test_max_zero();
        do_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd0;
        out_ready = 1'b1;
        src_limit = 1000;
        present();
        n_fire = 0;
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (n_fire != 0 || in_ready !== 1'b0 || stat_issued !== 32'd0) begin
            errors++; $display("FAIL max0_blocked: got fires=%0d in_ready=%0b issued=%0d expected 0/0/0", n_fire, in_ready, stat_issued); end
        cfg_max_queued_req_num = 6'd2;
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL out_ready_gate: got in_ready=%0b out_valid=%0b expected 0/1", in_ready, out_valid); end
        cyc();
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (n_fire != 2 || outstanding !== 6'd2) begin
            errors++; $display("FAIL max2_fires: got fires=%0d out=%0d expected 2/2", n_fire, outstanding); end
        stop_src();
    endtask

    task automatic test_lower_max();
        do_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd4;
        out_ready = 1'b1;
        src_limit = 3;
        present();
        n_fire = 0;
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (n_fire != 3 || outstanding !== 6'd3) begin
            errors++; $display("FAIL lower_setup: got fires=%0d out=%0d expected 3/3", n_fire, outstanding); end
        cfg_max_queued_req_num = 6'd1;
        src_limit = 1000;
        present();
        cyc();
        cyc();
        retire_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        retire_valid = 1'b0;
        checks++; if (n_fire != 3 || outstanding !== 6'd0) begin
            errors++; $display("FAIL lower_stalled: got fires=%0d out=%0d expected 3/0", n_fire, outstanding); end
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (n_fire != 4 || outstanding !== 6'd1) begin
            errors++; $display("FAIL lower_one_fire: got fires=%0d out=%0d expected 4/1", n_fire, outstanding); end
        stop_src();
    endtask

    task automatic test_underflow();
        do_reset();
        cfg_enable = 1'b1;
        cfg_max_queued_req_num = 6'd4;
        out_ready = 1'b1;
        retire_valid = 1'b1;
        cyc();
        retire_valid = 1'b0;
        checks++; if (err_underflow !== 1'b1 || outstanding !== 6'd0) begin
            errors++; $display("FAIL underflow_set: got err=%0b out=%0d expected 1/0", err_underflow, outstanding); end
        src_limit = 2;
        present();
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (err_underflow !== 1'b1 || outstanding !== 6'd2) begin
            errors++; $display("FAIL underflow_hold: got err=%0b out=%0d expected 1/2", err_underflow, outstanding); end
        stop_src();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (err_underflow !== 1'b0 || outstanding !== 6'd0 || stat_issued !== 32'd0 ||
                      stat_stall_cycles !== 32'd0 || draining !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got err=%0b out=%0d issued=%0d stall=%0d drain=%0b expected all 0",
                               err_underflow, outstanding, stat_issued, stat_stall_cycles, draining); end
        retire_valid = 1'b1;
        cyc();
        retire_valid = 1'b0;
        checks++; if (err_underflow !== 1'b1 || outstanding !== 6'd0) begin
            errors++; $display("FAIL post_reset_retire: got err=%0b out=%0d expected 1/0", err_underflow, outstanding); end
    endtask

    initial begin
        test_reset();
        test_fill_and_steady();
        test_drain();
        test_max_zero();
        test_lower_max();
        test_underflow();
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
